// File: rtl/mod_clk_monitor_pkg.sv
// Shared types and helpers for the modulation-clock monitor.
// Counter helpers work on 32-bit values so any CNT_W up to 32 can use them.
package mod_clk_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_DONE
    } state_t;

    localparam int NUM_IN   = 3;
    localparam int IDX_CLK  = 0;
    localparam int IDX_CLKN = 1;
    localparam int IDX_CLKL = 2;

    function automatic logic [31:0] all_ones(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        return (v >= all_ones(w)) ? all_ones(w) : (v + 32'd1);
    endfunction

endpackage

// File: rtl/mod_clk_monitor_edge_sync.sv
// Multi-flop synchronizer followed by registered rise/fall pulses.
// level is delayed to line up with the pulses, so level=1 in the cycle rise=1.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            level_q <= synced;
            rise_q  <= synced & ~level_q;
            fall_q  <= ~synced & level_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/mod_clk_monitor.sv
// Measures CLK_MOD period/high time, two-phase nonoverlap gap and CLKL phase lag
// over a START-triggered window of NUM_PERIODS periods; flags overlap and loss of clock.
module mod_clk_monitor #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned NUM_PERIODS = 8,
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             USER_CLOCK,
    input  logic             RST,
    input  logic             START,
    input  logic             CLK_MOD_IN,
    input  logic             CLKN_MOD_IN,
    input  logic             CLKL_MOD_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_TIME,
    output logic [CNT_W-1:0] MIN_GAP,
    output logic [CNT_W-1:0] PHASE_LAG,
    output logic             OVERLAP_ERR,
    output logic             TIMEOUT_ERR
);
    import mod_clk_monitor_pkg::*;

    localparam int unsigned PC_W = $clog2(NUM_PERIODS + 1);
    localparam logic [CNT_W-1:0] CNT_ONES = CNT_W'(all_ones(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(32'(v), CNT_W));
    endfunction

    logic [NUM_IN-1:0] async_in, lvl, rise, fall;
    assign async_in = {CLKL_MOD_IN, CLKN_MOD_IN, CLK_MOD_IN};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_sync
        edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk      (USER_CLOCK),
            .rst      (RST),
            .async_in (async_in[i]),
            .level    (lvl[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    logic unused_clkl;
    assign unused_clkl = lvl[IDX_CLKL] ^ fall[IDX_CLKL];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  period_cnt_q, period_cnt_d, high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]  gapa_cnt_q, gapa_cnt_d, gapb_cnt_q, gapb_cnt_d;
    logic [CNT_W-1:0]  lag_cnt_q, lag_cnt_d, to_cnt_q, to_cnt_d;
    logic              a_open_q, a_open_d, b_open_q, b_open_d, l_vld_q, l_vld_d;
    logic [PC_W-1:0]   pcount_q, pcount_d;
    // Working results; copied to the ports only when the window completes.
    logic [CNT_W-1:0]  period_w_q, period_w_d, high_w_q, high_w_d;
    logic [CNT_W-1:0]  gap_w_q, gap_w_d, lag_w_q, lag_w_d;
    logic              ovl_w_q, ovl_w_d, to_w_q, to_w_d;
    logic              gap_a_end, gap_b_end, to_expired;
    logic [CNT_W-1:0]  gap_a_val, gap_b_val;

    assign to_expired = (32'(to_cnt_q) + 32'd1) >= TIMEOUT_CYC;

    always_comb begin
        state_d      = state_q;
        period_cnt_d = inc(period_cnt_q);
        high_cnt_d   = inc(high_cnt_q);
        gapa_cnt_d   = inc(gapa_cnt_q);
        gapb_cnt_d   = inc(gapb_cnt_q);
        lag_cnt_d    = inc(lag_cnt_q);
        to_cnt_d     = inc(to_cnt_q);
        a_open_d     = a_open_q;
        b_open_d     = b_open_q;
        l_vld_d      = l_vld_q;
        pcount_d     = pcount_q;
        period_w_d   = period_w_q;
        high_w_d     = high_w_q;
        gap_w_d      = gap_w_q;
        lag_w_d      = lag_w_q;
        ovl_w_d      = ovl_w_q;
        to_w_d       = to_w_q;
        gap_a_end    = 1'b0;
        gap_a_val    = '0;
        gap_b_end    = 1'b0;
        gap_b_val    = '0;

        // Only the latest CLKL rise before a CLK_MOD rise counts toward the lag.
        if (rise[IDX_CLKL]) begin
            lag_cnt_d = CNT_ONE;
            l_vld_d   = 1'b1;
        end
        if (rise[IDX_CLK]) l_vld_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    ovl_w_d  = 1'b0;
                    to_w_d   = 1'b0;
                    gap_w_d  = CNT_ONES;
                    pcount_d = '0;
                    to_cnt_d = '0;
                    state_d  = ST_ARM;
                end
            end
            ST_ARM: begin
                if (rise[IDX_CLK]) begin
                    period_cnt_d = CNT_ONE;
                    high_cnt_d   = CNT_ONE;
                    gapa_cnt_d   = CNT_ONE;
                    gapb_cnt_d   = CNT_ONE;
                    a_open_d     = 1'b0;
                    b_open_d     = 1'b0;
                    to_cnt_d     = '0;
                    state_d      = ST_MEASURE;
                end else if (to_expired) begin
                    to_w_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_MEASURE: begin
                if (lvl[IDX_CLK] && lvl[IDX_CLKN]) ovl_w_d = 1'b1;

                if (fall[IDX_CLK]) begin
                    high_w_d   = high_cnt_q;
                    gapa_cnt_d = CNT_ONE;
                    a_open_d   = 1'b1;
                end
                if (fall[IDX_CLKN]) begin
                    gapb_cnt_d = CNT_ONE;
                    b_open_d   = 1'b1;
                end
                // An end edge with no open gap means the phases overlapped.
                if (rise[IDX_CLKN]) begin
                    gap_a_end = 1'b1;
                    a_open_d  = 1'b0;
                    if (fall[IDX_CLK])  gap_a_val = '0;
                    else if (a_open_q)  gap_a_val = gapa_cnt_q;
                    else                ovl_w_d   = 1'b1;
                end
                if (rise[IDX_CLK]) begin
                    gap_b_end = 1'b1;
                    b_open_d  = 1'b0;
                    if (fall[IDX_CLKN]) gap_b_val = '0;
                    else if (b_open_q)  gap_b_val = gapb_cnt_q;
                    else                ovl_w_d   = 1'b1;
                end
                if (gap_a_end && (gap_a_val < gap_w_d)) gap_w_d = gap_a_val;
                if (gap_b_end && (gap_b_val < gap_w_d)) gap_w_d = gap_b_val;

                if (rise[IDX_CLK]) begin
                    period_w_d   = period_cnt_q;
                    period_cnt_d = CNT_ONE;
                    high_cnt_d   = CNT_ONE;
                    to_cnt_d     = '0;
                    if (rise[IDX_CLKL]) lag_w_d = '0;
                    else if (l_vld_q)   lag_w_d = lag_cnt_q;
                    pcount_d = pcount_q + PC_W'(1);
                    if ((32'(pcount_q) + 32'd1) >= NUM_PERIODS) state_d = ST_DONE;
                end else if (to_expired) begin
                    to_w_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge USER_CLOCK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            gapa_cnt_q   <= '0;
            gapb_cnt_q   <= '0;
            lag_cnt_q    <= '0;
            to_cnt_q     <= '0;
            a_open_q     <= 1'b0;
            b_open_q     <= 1'b0;
            l_vld_q      <= 1'b0;
            pcount_q     <= '0;
            period_w_q   <= '0;
            high_w_q     <= '0;
            gap_w_q      <= CNT_ONES;
            lag_w_q      <= '0;
            ovl_w_q      <= 1'b0;
            to_w_q       <= 1'b0;
            PERIOD       <= '0;
            HIGH_TIME    <= '0;
            MIN_GAP      <= CNT_ONES;
            PHASE_LAG    <= '0;
            OVERLAP_ERR  <= 1'b0;
            TIMEOUT_ERR  <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            gapa_cnt_q   <= gapa_cnt_d;
            gapb_cnt_q   <= gapb_cnt_d;
            lag_cnt_q    <= lag_cnt_d;
            to_cnt_q     <= to_cnt_d;
            a_open_q     <= a_open_d;
            b_open_q     <= b_open_d;
            l_vld_q      <= l_vld_d;
            pcount_q     <= pcount_d;
            period_w_q   <= period_w_d;
            high_w_q     <= high_w_d;
            gap_w_q      <= gap_w_d;
            lag_w_q      <= lag_w_d;
            ovl_w_q      <= ovl_w_d;
            to_w_q       <= to_w_d;
            if (state_d == ST_DONE) begin
                PERIOD      <= period_w_d;
                HIGH_TIME   <= high_w_d;
                MIN_GAP     <= gap_w_d;
                PHASE_LAG   <= lag_w_d;
                OVERLAP_ERR <= ovl_w_d;
                TIMEOUT_ERR <= to_w_d;
            end
        end
    end

    assign BUSY = (state_q == ST_ARM) || (state_q == ST_MEASURE);
    assign DONE = (state_q == ST_DONE);

endmodule

// File: tb/tb_mod_clk_monitor.sv
// Directed bench: clock-pattern rows applied from a table, plus timeout/reset sequences.
module tb_mod_clk_monitor;

    logic        USER_CLOCK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        CLK_MOD_IN = 1'b0;
    logic        CLKN_MOD_IN = 1'b0;
    logic        CLKL_MOD_IN = 1'b0;
    logic        BUSY, DONE, OVERLAP_ERR, TIMEOUT_ERR;
    logic [15:0] PERIOD, HIGH_TIME, MIN_GAP, PHASE_LAG;

    int nchecks = 0;
    int nerrors = 0;

    mod_clk_monitor #(
        .CNT_W(16), .NUM_PERIODS(8), .TIMEOUT_CYC(100), .SYNC_STAGES(2)
    ) dut (
        .USER_CLOCK  (USER_CLOCK),
        .RST         (RST),
        .START       (START),
        .CLK_MOD_IN  (CLK_MOD_IN),
        .CLKN_MOD_IN (CLKN_MOD_IN),
        .CLKL_MOD_IN (CLKL_MOD_IN),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .PERIOD      (PERIOD),
        .HIGH_TIME   (HIGH_TIME),
        .MIN_GAP     (MIN_GAP),
        .PHASE_LAG   (PHASE_LAG),
        .OVERLAP_ERR (OVERLAP_ERR),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    always #5 USER_CLOCK = ~USER_CLOCK;

    // Pattern generator, one phase step per USER_CLOCK, driven on the falling edge.
    bit gen_en = 1'b0;
    int g_per = 20, g_hi = 8, g_ga = 2, g_nh = 8, g_lag = 5, g_ov = -1;
    int g_ph = 0, g_pno = 0, g_ns = 0;

    always @(negedge USER_CLOCK) begin
        if (!gen_en) begin
            g_ph = 0;
            g_pno = 0;
            CLK_MOD_IN = 1'b0;
            CLKN_MOD_IN = 1'b0;
            CLKL_MOD_IN = 1'b0;
        end else begin
            g_ns = g_hi + ((g_pno == g_ov) ? -2 : g_ga);
            CLK_MOD_IN  = (g_ph < g_hi);
            CLKN_MOD_IN = (g_ph >= g_ns) && (g_ph < g_ns + g_nh);
            CLKL_MOD_IN = (g_ph >= g_per - g_lag);
            g_ph++;
            if (g_ph == g_per) begin
                g_ph = 0;
                g_pno++;
            end
        end
    end

    typedef struct {
        string name;
        int per, hi, ga, nh, lag, ov_per, extra;
        int e_per, e_hi, e_gap, e_lag, e_ovl;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int got, input int exp);
        nchecks++;
        if (got != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge USER_CLOCK);
        #1;
    endtask

    task automatic run_row(input vec_t v);
        int done_at;
        int extra_done;
        gen_en = 1'b0;
        repeat (30) tick();
        g_per = v.per; g_hi = v.hi; g_ga = v.ga; g_nh = v.nh;
        g_lag = v.lag; g_ov = v.ov_per;
        gen_en = 1'b1;
        repeat (5) tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        check({v.name, "_busy"}, int'(BUSY), 1);
        done_at = -1;
        for (int c = 1; c <= 400 && done_at < 0; c++) begin
            START = (v.extra != 0) && (c == 40 || c == 90);
            tick();
            if (DONE) done_at = c;
        end
        START = 1'b0;
        check({v.name, "_done_in_window"},
              int'(done_at >= 8 * v.per + 1 && done_at <= 9 * v.per + 10), 1);
        check({v.name, "_period"},    int'(PERIOD),      v.e_per);
        check({v.name, "_high"},      int'(HIGH_TIME),   v.e_hi);
        check({v.name, "_min_gap"},   int'(MIN_GAP),     v.e_gap);
        check({v.name, "_phase_lag"}, int'(PHASE_LAG),   v.e_lag);
        check({v.name, "_overlap"},   int'(OVERLAP_ERR), v.e_ovl);
        check({v.name, "_timeout"},   int'(TIMEOUT_ERR), 0);
        tick();
        check({v.name, "_done_pulse"}, int'(DONE), 0);
        check({v.name, "_busy_after"}, int'(BUSY), 0);
        extra_done = 0;
        repeat (100) begin
            tick();
            if (DONE) extra_done++;
        end
        check({v.name, "_extra_done"}, extra_done, 0);
    endtask

    initial begin
        int done_at;

        vecs[0] = '{"nominal",   20, 8, 2, 8, 5, -1, 0, 20, 8, 2, 5, 0};
        vecs[1] = '{"asym_gap",  20, 8, 3, 8, 5, -1, 0, 20, 8, 1, 5, 0};
        vecs[2] = '{"overlap",   20, 8, 2, 8, 5,  4, 0, 20, 8, 0, 5, 1};
        vecs[3] = '{"busy_start",20, 8, 2, 8, 5, -1, 1, 20, 8, 2, 5, 0};

        // Reset with START held: reset must win.
        RST = 1'b1;
        START = 1'b1;
        repeat (3) tick();
        check("rst_start_busy", int'(BUSY), 0);
        START = 1'b0;
        RST = 1'b0;
        tick();
        check("rst_busy",    int'(BUSY), 0);
        check("rst_done",    int'(DONE), 0);
        check("rst_period",  int'(PERIOD), 0);
        check("rst_min_gap", int'(MIN_GAP), 16'hFFFF);
        check("rst_ovl",     int'(OVERLAP_ERR), 0);
        check("rst_to",      int'(TIMEOUT_ERR), 0);

        for (int i = 0; i < 4; i++) run_row(vecs[i]);

        // Timeout: no CLK_MOD activity at all after START.
        gen_en = 1'b0;
        repeat (30) tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        check("to_busy", int'(BUSY), 1);
        done_at = -1;
        for (int c = 1; c <= 300 && done_at < 0; c++) begin
            tick();
            if (DONE) done_at = c;
        end
        check("to_done_cycle", done_at, 100);
        check("to_err",       int'(TIMEOUT_ERR), 1);
        check("to_min_gap",   int'(MIN_GAP), 16'hFFFF);
        check("to_ovl",       int'(OVERLAP_ERR), 0);
        check("to_period_hold", int'(PERIOD), 20);
        tick();
        check("to_busy_after", int'(BUSY), 0);

        // Reset in the middle of a window, then a clean window.
        g_per = 20; g_hi = 8; g_ga = 2; g_nh = 8; g_lag = 5; g_ov = -1;
        gen_en = 1'b1;
        repeat (5) tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (60) tick();
        check("mid_busy_before", int'(BUSY), 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mid_rst_busy",    int'(BUSY), 0);
        check("mid_rst_done",    int'(DONE), 0);
        check("mid_rst_period",  int'(PERIOD), 0);
        check("mid_rst_high",    int'(HIGH_TIME), 0);
        check("mid_rst_lag",     int'(PHASE_LAG), 0);
        check("mid_rst_min_gap", int'(MIN_GAP), 16'hFFFF);
        check("mid_rst_ovl",     int'(OVERLAP_ERR), 0);
        check("mid_rst_to",      int'(TIMEOUT_ERR), 0);
        run_row(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/mod_clk_monitor.md
Name: mod_clk_monitor

Overview:
- Receive-side checker for the modulation clock outputs (CLK_MOD, CLKN_MOD, CLKL_MOD).
- Looped-back copies of the three clocks are sampled asynchronously on USER_CLOCK.
- Over a commanded window it measures CLK_MOD period and high time, the two-phase nonoverlap gap, and the CLKL-to-CLK_MOD phase lag, and flags overlap and loss of clock.
- It sits beside the clock generator in the top level, for bring-up and for checking the phase select.

Parameters:
- CNT_W, 16: width of all measurement counters and result ports.
- NUM_PERIODS, 8: CLK_MOD periods measured per window after the arming edge.
- TIMEOUT_CYC, 65535: USER_CLOCK cycles without a CLK_MOD rise before abort. Must be at most 2^CNT_W-1.
- SYNC_STAGES, 2: synchronizer flops per async input. Must be at least 2.

Ports:
- USER_CLOCK  in  1  sole clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begins a measurement window.
- CLK_MOD_IN  in  1  async looped-back CLK_MOD.
- CLKN_MOD_IN  in  1  async looped-back CLKN_MOD.
- CLKL_MOD_IN  in  1  async looped-back CLKL_MOD.
- BUSY  out  1  high in ARM and MEASURE.
- DONE  out  1  one-cycle pulse when results are valid.
- PERIOD  out  CNT_W  last CLK_MOD rise-to-rise interval, in cycles.
- HIGH_TIME  out  CNT_W  last CLK_MOD rise-to-fall interval.
- MIN_GAP  out  CNT_W  minimum nonoverlap gap over the window.
- PHASE_LAG  out  CNT_W  last CLKL rise to the next CLK_MOD rise.
- OVERLAP_ERR  out  1  CLK_MOD and CLKN both high in some cycle of the window.
- TIMEOUT_ERR  out  1  window aborted on timeout.

Behaviour:
- Clock and reset: one clock (USER_CLOCK); RST is synchronous and active-high.
- Reset values: state IDLE; BUSY=0, DONE=0, PERIOD=0, HIGH_TIME=0, PHASE_LAG=0, OVERLAP_ERR=0, TIMEOUT_ERR=0; MIN_GAP = all-ones; synchronizer flops = 0.
- Input path: each input passes through SYNC_STAGES flops, then a registered rise/fall detector.
  - Latency is identical on all three inputs, so measured intervals equal the input intervals, quantized to USER_CLOCK.
  - An interval is the difference in cycle index between the two detected edges. Edges detected in the same cycle give 0.
- Input rate: intervals under 2 cycles are quantization-limited and are not checked.
- Counters: all saturate at 2^CNT_W-1 and never wrap.
- State IDLE:
  - On START: OVERLAP_ERR=0, TIMEOUT_ERR=0, MIN_GAP = all-ones, period count = 0, go to ARM.
- State ARM:
  - On a CLK_MOD rise: restart the period, high and gap counters and go to MEASURE. This rise is not counted.
  - The timeout counter runs from entry to ARM.
- State MEASURE:
  - CLK_MOD rise: PERIOD_r = period counter; period count +1; restart the period counter.
  - CLK_MOD fall: HIGH_TIME_r = high counter.
  - Gap A runs from a CLK_MOD fall to the next CLKN rise. Gap B runs from a CLKN fall to the next CLK_MOD rise.
  - At the end of each gap: MIN_GAP_r = min(MIN_GAP_r, gap).
  - If the end edge is detected in the same cycle as the start edge, the gap is 0.
  - If the end edge precedes the start edge, the gap is 0 and OVERLAP_ERR is set.
  - PHASE_LAG_r = cycles from the latest CLKL rise to the next CLK_MOD rise. A coincident CLKL/CLK_MOD rise gives 0.
  - If synced CLK_MOD=1 and CLKN=1 in the same cycle, OVERLAP_ERR is set (sticky until next START).
  - On the NUM_PERIODS-th counted rise, go to DONE.
- Timeout: in ARM or MEASURE, if TIMEOUT_CYC cycles pass with no CLK_MOD rise, set TIMEOUT_ERR=1 and go to DONE. The timeout counter restarts on every CLK_MOD rise.
- State DONE:
  - DONE=1 for exactly one cycle. Result registers drive the output ports (updated on entry to DONE, held until the next DONE).
  - Then go to IDLE.
  - After a timeout, the outputs hold whatever was last captured; MIN_GAP stays all-ones if no gap completed.
- START while BUSY or in DONE: ignored.
- RST at any time: all outputs take their reset values on that clock edge. A partial window is discarded.
- Simultaneous RST and START: RST wins.

Decomposition:
- Package mod_clk_monitor_pkg holds:
  - the state encoding (IDLE, ARM, MEASURE, DONE);
  - the saturating-increment function;
  - the all-ones constant helper for CNT_W.
- Sub-module edge_sync (SYNC_STAGES synchronizer plus registered rise/fall pulses), instantiated 3x.

Test Plan:
1. Nominal, with TIMEOUT_CYC=100.
   - Stimulus: CLK_MOD period 20, high 8; CLKN high 8, rising 2 cycles after the CLK_MOD fall; CLKL rising 5 cycles before each CLK_MOD rise; one START.
   - Response: DONE once, 8 periods after arming; PERIOD=20, HIGH_TIME=8, MIN_GAP=2, PHASE_LAG=5, both error flags 0, BUSY low after DONE.
2. Asymmetric gaps.
   - Stimulus: gap A=3, gap B=1, period 20.
   - Response: MIN_GAP=1, OVERLAP_ERR=0.
3. Overlap.
   - Stimulus: CLKN rises 2 cycles before the CLK_MOD fall in one period of the window.
   - Response: OVERLAP_ERR=1, MIN_GAP=0, DONE still after 8 periods.
4. Timeout, with TIMEOUT_CYC=100.
   - Stimulus: CLK_MOD held low after START.
   - Response: DONE exactly 100 cycles after entering ARM, TIMEOUT_ERR=1, MIN_GAP = all-ones.
5. Reset mid-window.
   - Stimulus: RST for 1 cycle during MEASURE, then a new START.
   - Response: next cycle BUSY=0 and all outputs at reset values; the new window reports the nominal values from scenario 1.
6. START while BUSY.
   - Stimulus: extra START pulses during MEASURE.
   - Response: no restart, a single DONE, results identical to scenario 1.
